vedic_mult_seq: RTL and testbench
=================================

# vedic_mult_seq

Parametrised sequential Urdhva-Tiryagbhyam (vertical-and-crosswise) unsigned multiplier. It is the successor to the fixed 2x2 combinational vedic multiplier. It generalises the operand width to WIDTH bits and computes one product column per clock, so area stays small at large widths. Operands enter and products leave over valid/ready handshakes. The block sits as a multiply engine behind a register interface or datapath sequencer.

## Interface
- WIDTH, default 4: operand width in bits; any integer ≥ 2.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand pair a/b is valid.
- in_ready  out  1  block can accept operands; high exactly in IDLE.
- a  in  WIDTH  multiplicand, unsigned.
- b  in  WIDTH  multiplier, unsigned.
- out_valid  out  1  product is valid; high exactly in DONE.
- out_ready  in  1  consumer accepts the product.
- product  out  2*WIDTH  unsigned a*b, registered.
- busy  out  1  high in RUN.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: iterating over columns.
  - DONE: out_valid=1, product stable.
- IDLE → RUN on in_valid & in_ready.
  - Latch a and b.
  - Set col=0 and carry=0.
  - Clear product to 0.
- RUN, column k = col, range 0..2*WIDTH-2:
  - s = carry + Σ (a[i] & b[k-i]), summed over every i with 0≤i<WIDTH and 0≤k-i<WIDTH.
  - product[k] ← s[0].
  - carry ← s >> 1.
  - col ← col+1.
- RUN → DONE when col == 2*WIDTH-2.
  - In the same cycle, product[2*WIDTH-1] ← (s >> 1)[0].
  - The final carry is provably ≤ 1.
- DONE → IDLE on out_ready.
  - product holds its value until the next accept clears it.
- Width rules:
  - carry register is CW = clog2(2*WIDTH)+1 bits.
  - The column sum never exceeds 2*WIDTH-1, so no overflow.
- in_valid outside IDLE is ignored. No operand is latched and no error is flagged.
- No overlap: a new accept is not possible in the same cycle DONE is left. in_ready rises the cycle after the out handshake.
- Reset, asserted at any time including mid-RUN, does the following immediately and asynchronously:
  - state → IDLE.
  - product, col and carry → 0.
  - Latched operands → 0.
  - out_valid=0, busy=0, in_ready=1.
  - The in-flight operation is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, product=0.
- Handshake at edge T (in_valid & in_ready):
  - RUN occupies cycles T+1 … T+2*WIDTH-1, which is 2*WIDTH-1 columns.
  - out_valid rises at T+2*WIDTH.
  - Latency = 2*WIDTH cycles, input handshake to output valid. WIDTH=4 gives 8.
- out_valid stays high, with product stable, for as many cycles as out_ready is low.
- Minimum initiation interval = 2*WIDTH+1 cycles, with out_ready held high.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid or out_ready to any output.

## Structure
- Package vedic_pkg:
  - State enum vedic_state_t (IDLE, RUN, DONE).
  - Function vedic_carry_w(width) returning CW.
  - Function vedic_cols(width) returning 2*width-1.
- Sub-module vedic_column_sum:
  - Combinational.
  - Parameter WIDTH.
  - Inputs: a, b, col.
  - Output: popcount of the crosswise partial-product bits of column col, clog2(WIDTH+1) bits.
  - Instantiated once. The parent adds carry.
- The parent holds the FSM, column counter, carry register and product shift/write logic.

## Test plan
- WIDTH=2, all 16 (a,b) pairs back-to-back with out_ready=1:
  - Each product equals a*b.
  - out_valid asserts exactly 4 cycles after each accept. Example: 3*3=9.
- WIDTH=4, a=15, b=15:
  - product=225 (0xE1) at handshake+8.
  - busy high for exactly 7 cycles.
  - Then a=0, b=13 → product=0.
- WIDTH=8, a=255, b=255:
  - product=65025 (0xFE01), latency 16.
  - Check against a random-operand scoreboard over 1000 ops.
- Backpressure, WIDTH=4, a=9, b=7:
  - Hold out_ready=0 for 5 cycles: out_valid stays 1 and product stays 63.
  - in_ready stays 0.
  - in_valid pulses during RUN/DONE (operands a=1, b=1) are ignored; the next product must be from the next accepted pair.
- Reset mid-RUN, WIDTH=4, a=12, b=11:
  - Assert rst at column 3, asynchronously between edges.
  - Outputs go immediately to in_ready=1, busy=0, out_valid=0, product=0.
  - After release, a=5, b=6 → product=30 at +8.

Source files
------------

// File: rtl/vedic_pkg.sv
// Shared types and width helpers for the sequential vedic multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vedic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } vedic_state_t;

  // Carry register width: the column sum stays below 2*width, plus one spare bit.
  function automatic int vedic_carry_w(input int width);
    return $clog2(2 * width) + 1;
  endfunction

  // Number of product columns walked by the crosswise pass.
  function automatic int vedic_cols(input int width);
    return 2 * width - 1;
  endfunction

endpackage

// File: rtl/vedic_column_sum.sv
// Popcount of the crosswise partial-product bits a[i]&b[j] with i+j == col.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module vedic_column_sum
  import vedic_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]            a,
  input  logic [WIDTH-1:0]            b,
  input  logic [$clog2(2*WIDTH)-1:0]  col,
  output logic [$clog2(WIDTH+1)-1:0]  sum
);

  localparam int SW = $clog2(WIDTH + 1);

  // At most WIDTH bits land in one column, so SW bits never overflow.
  always_comb begin
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (i + j == int'(col)) begin
          sum = sum + SW'(a[i] & b[j]);
        end
      end
    end
  end

endmodule

// File: rtl/vedic_mult_seq.sv
// Sequential Urdhva-Tiryagbhyam unsigned multiplier, one product column per clock.
// Latency: 2*WIDTH cycles from input handshake to out_valid; II 2*WIDTH+1.
// Backpressure: product held in DONE while out_ready low; in_ready only in IDLE.
module vedic_mult_seq
  import vedic_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CW  = vedic_carry_w(WIDTH);
  localparam int CLW = $clog2(2 * WIDTH);
  localparam int SW  = $clog2(WIDTH + 1);
  localparam logic [CLW-1:0] LAST_COL = CLW'(vedic_cols(WIDTH) - 1);

  vedic_state_t     state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CLW-1:0]   col;
  logic [CW-1:0]    carry;
  logic [SW-1:0]    col_pop;
  logic [CW-1:0]    s;

  vedic_column_sum #(
    .WIDTH (WIDTH)
  ) u_column_sum (
    .a   (a_q),
    .b   (b_q),
    .col (col),
    .sum (col_pop)
  );

  // Running column total; bounded by 2*WIDTH-1 so it fits the carry width.
  assign s = carry + CW'(col_pop);

  // Control FSM, column walk, carry chain and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      col       <= '0;
      carry     <= '0;
      product   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= RUN;
            a_q      <= a;
            b_q      <= b;
            col      <= '0;
            carry    <= '0;
            product  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          product[col] <= s[0];
          carry        <= s >> 1;
          if (col == LAST_COL) begin
            // The leftover carry is at most one, so it fills the top bit alone.
            product[2*WIDTH-1] <= s[1];
            state              <= DONE;
            busy               <= 1'b0;
            out_valid          <= 1'b1;
          end else begin
            col <= col + CLW'(1);
          end
        end
        DONE: begin
          // in_ready rises only after this edge, so accepts never overlap the exit.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_mult_seq.sv
// Directed bench for vedic_mult_seq at WIDTH 2, 4 and 8 with immediate assertions.
// Latency: counted with the accept cycle as cycle 0.
// Backpressure: exercised by holding out_ready low in DONE.
module tb_vedic_mult_seq;

  logic clk;
  logic rst;

  logic [7:0] ta;
  logic [7:0] tb;
  logic       tiv;
  logic       tordy;
  int         sel;

  int n_cmp;
  int n_fail;

  logic       ir2, ov2, bz2;
  logic [3:0] p2;
  logic       ir4, ov4, bz4;
  logic [7:0] p4;
  logic       ir8, ov8, bz8;
  logic [15:0] p8;

  logic        c_ir, c_ov, c_busy;
  logic [15:0] c_p;

  vedic_mult_seq #(.WIDTH(2)) u_w2 (
    .clk (clk), .rst (rst),
    .in_valid (tiv && (sel == 2)), .in_ready (ir2),
    .a (ta[1:0]), .b (tb[1:0]),
    .out_valid (ov2), .out_ready (tordy),
    .product (p2), .busy (bz2)
  );

  vedic_mult_seq #(.WIDTH(4)) u_w4 (
    .clk (clk), .rst (rst),
    .in_valid (tiv && (sel == 4)), .in_ready (ir4),
    .a (ta[3:0]), .b (tb[3:0]),
    .out_valid (ov4), .out_ready (tordy),
    .product (p4), .busy (bz4)
  );

  vedic_mult_seq #(.WIDTH(8)) u_w8 (
    .clk (clk), .rst (rst),
    .in_valid (tiv && (sel == 8)), .in_ready (ir8),
    .a (ta), .b (tb),
    .out_valid (ov8), .out_ready (tordy),
    .product (p8), .busy (bz8)
  );

  // Route the selected instance's outputs to a common set of probes.
  always_comb begin
    c_ir = ir4; c_ov = ov4; c_busy = bz4; c_p = {8'b0, p4};
    case (sel)
      2: begin c_ir = ir2; c_ov = ov2; c_busy = bz2; c_p = {12'b0, p2}; end
      8: begin c_ir = ir8; c_ov = ov8; c_busy = bz8; c_p = p8; end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One operation: wait for in_ready, handshake, then wait for out_valid.
  // With junk set, in_valid stays high carrying a=1,b=1 after the accept.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic junk,
                        output logic [15:0] p, output int lat, output int bcyc);
    logic seen;
    int   k;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (c_ir) begin seen = 1'b1; break; end
    end
    check("in_ready_seen", 32'(seen), 32'd1);
    ta = av; tb = bv; tiv = 1'b1;
    @(posedge clk); #1;
    tiv = junk;
    if (junk) begin ta = 8'd1; tb = 8'd1; end
    k = 0; bcyc = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (c_busy) bcyc++;
      if (c_ov) begin seen = 1'b1; break; end
      @(posedge clk);
      k++;
    end
    check("out_valid_seen", 32'(seen), 32'd1);
    lat = k + 1;
    p   = c_p;
  endtask

  initial begin
    logic [15:0] p;
    int          lat;
    int          bc;
    logic [7:0]  ra;
    logic [7:0]  rb;

    n_cmp = 0; n_fail = 0;
    ta = '0; tb = '0; tiv = 1'b0; tordy = 1'b1; sel = 4;
    rst = 1'b1;
    #1;
    check("reset_in_ready", 32'(c_ir), 32'd1);
    check("reset_out_valid", 32'(c_ov), 32'd0);
    check("reset_busy", 32'(c_busy), 32'd0);
    check("reset_product", 32'(c_p), 32'd0);
    #11 rst = 1'b0;

    // WIDTH=2: every operand pair back-to-back, latency 4.
    sel = 2;
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        run_op(8'(x), 8'(y), 1'b0, p, lat, bc);
        check($sformatf("w2_prod_%0dx%0d", x, y), 32'(p), 32'(x * y));
        check($sformatf("w2_lat_%0dx%0d", x, y), 32'(lat), 32'd4);
      end
    end

    // WIDTH=4: full-scale operands, then a zero operand.
    sel = 4;
    run_op(8'd15, 8'd15, 1'b0, p, lat, bc);
    check("w4_15x15", 32'(p), 32'd225);
    check("w4_15x15_lat", 32'(lat), 32'd8);
    check("w4_15x15_busy", 32'(bc), 32'd7);
    run_op(8'd0, 8'd13, 1'b0, p, lat, bc);
    check("w4_0x13", 32'(p), 32'd0);

    // WIDTH=8: full-scale operands, then a random scoreboard.
    sel = 8;
    run_op(8'd255, 8'd255, 1'b0, p, lat, bc);
    check("w8_255x255", 32'(p), 32'd65025);
    check("w8_255x255_lat", 32'(lat), 32'd16);
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(ra, rb, 1'b0, p, lat, bc);
      check($sformatf("w8_rand_%0d_%0dx%0d", n, ra, rb), 32'(p), 32'(ra) * 32'(rb));
    end

    // Backpressure with stray in_valid pulses during RUN and DONE.
    sel = 4;
    tordy = 1'b0;
    run_op(8'd9, 8'd7, 1'b1, p, lat, bc);
    check("bp_9x7", 32'(p), 32'd63);
    check("bp_9x7_lat", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold_ov_%0d", i), 32'(c_ov), 32'd1);
      check($sformatf("bp_hold_prod_%0d", i), 32'(c_p), 32'd63);
      check($sformatf("bp_hold_ir_%0d", i), 32'(c_ir), 32'd0);
      @(negedge clk);
    end
    tiv = 1'b0;
    tordy = 1'b1;
    @(negedge clk);
    check("bp_release_ov", 32'(c_ov), 32'd0);
    check("bp_release_ir", 32'(c_ir), 32'd1);
    run_op(8'd2, 8'd3, 1'b0, p, lat, bc);
    check("bp_next_2x3", 32'(p), 32'd6);

    // Asynchronous reset in the middle of column 3 of 12*11.
    @(negedge clk);
    check("rst_pre_ir", 32'(c_ir), 32'd1);
    ta = 8'd12; tb = 8'd11; tiv = 1'b1;
    @(posedge clk); #1;
    tiv = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_partial_prod", 32'(c_p), 32'd4);
    check("rst_partial_busy", 32'(c_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_ir", 32'(c_ir), 32'd1);
    check("rst_mid_busy", 32'(c_busy), 32'd0);
    check("rst_mid_ov", 32'(c_ov), 32'd0);
    check("rst_mid_prod", 32'(c_p), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    run_op(8'd5, 8'd6, 1'b0, p, lat, bc);
    check("rst_after_5x6", 32'(p), 32'd30);
    check("rst_after_5x6_lat", 32'(lat), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
